// File: rtl/clk_speed_gen.sv
// clk_speed_gen: programmable-frequency 50%-duty clock generator.
// The half-period limit floor(CLK_HZ/(2*f)), clamped to at least 1, comes from
// an on-block restoring divider, one quotient bit per clock. A new limit waits
// in a shadow register and is applied at the next half-period boundary, so
// clkout never produces a runt half-period.
//
// Optional feature macro: CLK_SPEED_PULSE_EN (adds the 'tick' output).
//
// Ports:
//   clkin    system clock, rising edge
//   rst      asynchronous active-high reset
//   clken    count enable; counter and clkout freeze while low
//   freq_wr  one-cycle strobe requesting a new frequency
//   freq_in  requested frequency in Hz, sampled on freq_wr && !busy
//   busy     division or load in progress; writes are ignored while high
//   pending  a computed limit waits for the next half-period boundary
//   running  active limit is nonzero, clkout toggles
//   clkout   generated clock
//   tick     (CLK_SPEED_PULSE_EN only) one-cycle strobe with each clkout rise
module clk_speed_gen #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned FREQ_W       = 10,
  parameter int unsigned DIV_W        = 32,
  parameter int unsigned DEFAULT_FREQ = 1
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              clken,
  input  logic              freq_wr,
  input  logic [FREQ_W-1:0] freq_in,
  output logic              busy,
  output logic              pending,
  output logic              running,
  output logic              clkout
`ifdef CLK_SPEED_PULSE_EN
  ,
  output logic              tick
`endif
);

  localparam int unsigned DVS_W = FREQ_W + 1;
  localparam int unsigned TRL_W = DVS_W + 1;
  localparam int unsigned IDX_W = $clog2(DIV_W + 1);

  // Elaboration-time limit for the reset frequency.
  function automatic logic [DIV_W-1:0] limit_of(input int unsigned f);
    longint unsigned q;
    if (f == 0) return '0;
    q = 64'(CLK_HZ) / (64'(2) * 64'(f));
    if (q == 0) return DIV_W'(1);
    return DIV_W'(q);
  endfunction

  localparam logic [DIV_W-1:0] DEF_LIMIT = limit_of(DEFAULT_FREQ);
  localparam logic [DIV_W-1:0] DIVIDEND  = DIV_W'(CLK_HZ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DVS_W-1:0]  dvs_q, dvs_d;
  logic [DVS_W-1:0]  rem_q, rem_d;
  logic [DIV_W-1:0]  quo_q, quo_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIV_W-1:0]  shadow_q, shadow_d;
  logic [DIV_W-1:0]  limit_q, limit_d;
  logic [DIV_W-1:0]  count_q, count_d;
  logic              pending_q, pending_d;
  logic              clkout_q, clkout_d;
  logic              busy_q, busy_d;
  logic              running_q, running_d;
  logic [TRL_W-1:0]  trial;
  logic              ge;
`ifdef CLK_SPEED_PULSE_EN
  logic              tick_q, tick_d;
`endif

  // Restoring divide step: the quotient register starts as the dividend and
  // shifts its MSB into the partial remainder while quotient bits enter at the LSB.
  assign trial = {rem_q, quo_q[DIV_W-1]};
  assign ge    = (trial >= {1'b0, dvs_q});

  // Next-state logic for divider, half-period counter and outputs.
  always_comb begin
    state_d   = state_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    limit_d   = limit_q;
    count_d   = count_q;
    pending_d = pending_q;
    clkout_d  = clkout_q;
`ifdef CLK_SPEED_PULSE_EN
    tick_d    = 1'b0;
`endif

    // Counter; a stopped generator takes a pending limit at once.
    if (limit_q == '0) begin
      if (pending_q) begin
        limit_d   = shadow_q;
        pending_d = 1'b0;
        count_d   = '0;
      end
    end else if (clken) begin
      if (count_q == limit_q - DIV_W'(1)) begin
        count_d  = '0;
        clkout_d = ~clkout_q;
`ifdef CLK_SPEED_PULSE_EN
        tick_d   = ~clkout_q;
`endif
        if (pending_q) begin
          limit_d   = shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        count_d = count_q + DIV_W'(1);
      end
    end

    // Divider FSM; a LOAD overrides a same-cycle shadow take so the newest result wins.
    unique case (state_q)
      S_IDLE: begin
        if (freq_wr) begin
          rem_d = '0;
          if (freq_in != '0) begin
            dvs_d   = {freq_in, 1'b0};
            quo_d   = DIVIDEND;
            idx_d   = IDX_W'(DIV_W - 1);
            state_d = S_DIV;
          end else begin
            dvs_d   = '0;
            quo_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_DIV: begin
        rem_d = ge ? DVS_W'(trial - {1'b0, dvs_q}) : DVS_W'(trial);
        quo_d = {quo_q[DIV_W-2:0], ge};
        if (idx_q == '0) begin
          state_d = S_LOAD;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_LOAD: begin
        shadow_d  = (quo_q == '0 && dvs_q != '0) ? DIV_W'(1) : quo_q;
        pending_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    running_d = (limit_d != '0);
  end

  // State registers.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      limit_q   <= DEF_LIMIT;
      count_q   <= '0;
      pending_q <= 1'b0;
      clkout_q  <= 1'b0;
      busy_q    <= 1'b0;
      running_q <= (DEF_LIMIT != '0);
`ifdef CLK_SPEED_PULSE_EN
      tick_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      clkout_q  <= clkout_d;
      busy_q    <= busy_d;
      running_q <= running_d;
`ifdef CLK_SPEED_PULSE_EN
      tick_q    <= tick_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign pending = pending_q;
  assign running = running_q;
  assign clkout  = clkout_q;
`ifdef CLK_SPEED_PULSE_EN
  assign tick    = tick_q;
`endif

endmodule

// File: tb/tb_clk_speed_gen.sv
// Randomized bench for clk_speed_gen with a transaction-level reference model:
// the limit is computed by a plain divide, busy is a countdown, and the
// generator is modelled as "toggle after limit enabled cycles".
module tb_clk_speed_gen;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned FREQ_W = 10;
  localparam int unsigned DIV_W  = 32;
  localparam int unsigned DEF_F  = 0;

  logic              clkin = 1'b0;
  logic              rst;
  logic              clken;
  logic              freq_wr;
  logic [FREQ_W-1:0] freq_in;
  logic              busy;
  logic              pending;
  logic              running;
  logic              clkout;
`ifdef CLK_SPEED_PULSE_EN
  logic              tick;
`endif

  clk_speed_gen #(
    .CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W), .DIV_W(DIV_W), .DEFAULT_FREQ(DEF_F)
  ) dut (
    .clkin(clkin), .rst(rst), .clken(clken), .freq_wr(freq_wr),
    .freq_in(freq_in), .busy(busy), .pending(pending), .running(running),
    .clkout(clkout)
`ifdef CLK_SPEED_PULSE_EN
    , .tick(tick)
`endif
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int unsigned m_limit, m_shadow, m_result, m_count, m_busy_left;
  bit          m_pending, m_clkout, m_tick;

  function automatic int unsigned lim(input int unsigned f);
    int unsigned q;
    if (f == 0) return 0;
    q = CLK_HZ / (2 * f);
    return (q == 0) ? 1 : q;
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_limit     = lim(DEF_F);
    m_shadow    = 0;
    m_result    = 0;
    m_count     = 0;
    m_busy_left = 0;
    m_pending   = 0;
    m_clkout    = 0;
    m_tick      = 0;
  endtask

  task automatic model_edge(input logic r, input logic wr, input int unsigned fin, input logic ce);
    if (r) begin
      model_reset();
      return;
    end
    m_tick = 0;
    if (m_limit == 0) begin
      if (m_pending) begin
        m_limit   = m_shadow;
        m_pending = 0;
        m_count   = 0;
      end
    end else if (ce) begin
      if (m_count == m_limit - 1) begin
        m_count  = 0;
        m_clkout = ~m_clkout;
        m_tick   = m_clkout;
        if (m_pending) begin
          m_limit   = m_shadow;
          m_pending = 0;
        end
      end else begin
        m_count++;
      end
    end
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_shadow  = m_result;
        m_pending = 1;
      end
    end else if (wr) begin
      m_result    = lim(fin);
      m_busy_left = (fin != 0) ? DIV_W + 1 : 1;
    end
  endtask

  task automatic compare_all();
    check("busy",    32'(busy),    32'(m_busy_left > 0));
    check("pending", 32'(pending), 32'(m_pending));
    check("running", 32'(running), 32'(m_limit != 0));
    check("clkout",  32'(clkout),  32'(m_clkout));
`ifdef CLK_SPEED_PULSE_EN
    check("tick",    32'(tick),    32'(m_tick));
`endif
  endtask

  task automatic step(input logic r, input logic wr, input int unsigned fin, input logic ce);
    rst     = r;
    freq_wr = wr;
    freq_in = FREQ_W'(fin);
    clken   = ce;
    @(posedge clkin);
    model_edge(r, wr, fin, ce);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b1);
  endtask

  int  blen;
  int  gap;
  int  last_gap;
  bit  prev_clk;

  initial begin
    rst = 1'b1; clken = 1'b1; freq_wr = 1'b0; freq_in = '0;
    #1;
    model_reset();
    compare_all();
    step(1'b1, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    idle(100);
    check("stopped_clkout", 32'(clkout), 0);

    // 100 Hz: busy for the full division, then a 5-cycle half-period.
    step(1'b0, 1'b1, 100, 1'b1);
    blen = 0;
    while (busy && blen < 100) begin
      blen++;
      step(1'b0, 1'b0, 0, 1'b1);
    end
    check("busy_len", 32'(blen), 33);
    idle(60);

    // Retune to 50 Hz mid-run; the last observed half-period must be 10.
    step(1'b0, 1'b1, 50, 1'b1);
    gap = 0; last_gap = 0; prev_clk = clkout;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b0, 0, 1'b1);
      gap++;
      if (clkout != prev_clk) begin
        last_gap = gap;
        gap = 0;
        prev_clk = clkout;
      end
    end
    check("half_50", 32'(last_gap), 10);

    // Clamped limit, then stop, with a write ignored while busy.
    step(1'b0, 1'b1, 600, 1'b1);
    idle(45);
    step(1'b0, 1'b1, 0, 1'b1);
    step(1'b0, 1'b1, 300, 1'b1);
    idle(50);
    check("stopped_after_0", 32'(running), 0);

    // Freeze with clken low mid-half-period.
    step(1'b0, 1'b1, 100, 1'b1);
    idle(40);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 1'b0);
    idle(30);

    // Asynchronous reset in the middle of a division.
    step(1'b0, 1'b1, 200, 1'b1);
    idle(10);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    step(1'b1, 1'b0, 0, 1'b1);
    idle(5);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic r, wr, ce;
      int unsigned f;
      r  = ($urandom_range(0, 1499) == 0);
      wr = ($urandom_range(0, 29) == 0);
      ce = ($urandom_range(0, 7) != 0);
      f  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(50, 1023);
      step(r, wr, f, ce);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
